// File: rtl/fpu_div_frac_seq_pkg.sv
// Shared types and defaults for the divide fraction sequencer.
package fpu_div_seq_pkg;

    localparam int unsigned ITER_DBL_DEF = 55;
    localparam int unsigned ITER_SNG_DEF = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_LZC,
        ST_PREP,
        ST_ITER,
        ST_RND,
        ST_DONE
    } div_state_t;

    function automatic int unsigned iter_count(
        input logic        dbl,
        input int unsigned n_dbl,
        input int unsigned n_sng
    );
        return dbl ? n_dbl : n_sng;
    endfunction

endpackage

// File: rtl/fpu_div_frac_seq_if.sv
// Issue/result handshake plus datapath strobes between sequencer and its neighbours.
interface fpu_div_frac_seq_if;
    logic div_req;
    logic div_dbl;
    logic div_special;
    logic div_kill;
    logic div_res_ack;
    logic div_req_ack;
    logic div_busy;
    logic div_res_vld;
    logic fdiv_clken_l;
    logic d1stg_step;
    logic d3stg_fdiv;
    logic d4stg_fdiv;
    logic d5stg_fdivb;
    logic d6stg_fdiv;
    logic d6stg_fdivd;
    logic d6stg_fdivs;
    logic div_frac_add_in1_add;
    logic div_frac_add_in1_load;
    logic div_frac_add_in2_load;
    logic div_frac_out_shl1_dbl;
    logic div_frac_out_shl1_sng;
    logic div_frac_out_load;

    modport master (
        output div_req, div_dbl, div_special, div_kill, div_res_ack,
        input  div_req_ack, div_busy, div_res_vld, fdiv_clken_l, d1stg_step,
        input  d3stg_fdiv, d4stg_fdiv, d5stg_fdivb, d6stg_fdiv, d6stg_fdivd, d6stg_fdivs,
        input  div_frac_add_in1_add, div_frac_add_in1_load, div_frac_add_in2_load,
        input  div_frac_out_shl1_dbl, div_frac_out_shl1_sng, div_frac_out_load
    );

    modport slave (
        input  div_req, div_dbl, div_special, div_kill, div_res_ack,
        output div_req_ack, div_busy, div_res_vld, fdiv_clken_l, d1stg_step,
        output d3stg_fdiv, d4stg_fdiv, d5stg_fdivb, d6stg_fdiv, d6stg_fdivd, d6stg_fdivs,
        output div_frac_add_in1_add, div_frac_add_in1_load, div_frac_add_in2_load,
        output div_frac_out_shl1_dbl, div_frac_out_shl1_sng, div_frac_out_load
    );
endinterface

// File: rtl/fpu_div_frac_seq_iter_cnt.sv
// Loadable down-counter for the quotient iterations; holds at zero instead of wrapping.
module fpu_div_iter_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge rclk) begin
        if (rst)
            r_value <= '0;
        else if (i_load)
            r_value <= i_load_val;
        else if (i_dec && (r_value != '0))
            r_value <= r_value - 1'b1;
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule

// File: rtl/fpu_div_frac_seq.sv
// Divide fraction sequencer: walks the datapath from capture through iterations to round-prep.
//   state | meaning
//   IDLE  | waiting for div_req      NORM | norm register captures
//   LZC   | shift-save load          PREP | operand load, quotient clear, counter load
//   ITER  | non-restoring iteration  RND  | round-prep
//   DONE  | result valid until ack
module fpu_div_frac_seq
    import fpu_div_seq_pkg::*;
#(
    parameter int unsigned ITER_DBL = ITER_DBL_DEF,
    parameter int unsigned ITER_SNG = ITER_SNG_DEF,
    parameter int          CNT_W    = 6
) (
    input logic               rclk,
    input logic               rst,
    fpu_div_frac_seq_if.slave div
);

    div_state_t       r_state;
    logic             r_dbl;
    logic             r_special;
    logic             w_accept;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val;
    logic [CNT_W-1:0] w_cnt_init;

    assign w_accept   = (r_state == ST_IDLE) && div.div_req;
    assign w_cnt_init = CNT_W'(iter_count(r_dbl, ITER_DBL, ITER_SNG) - 1);

    fpu_div_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
        .rclk       (rclk),
        .rst        (rst),
        .i_load     (r_state == ST_PREP),
        .i_dec      (r_state == ST_ITER),
        .i_load_val (w_cnt_init),
        .o_value    (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_dbl     <= 1'b0;
            r_special <= 1'b0;
        end else if (div.div_kill && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_state   <= ST_NORM;
                    r_dbl     <= div.div_dbl;
                    r_special <= div.div_special;
                end
                ST_NORM: r_state <= ST_LZC;
                ST_LZC:  r_state <= ST_PREP;
                ST_PREP: r_state <= r_special ? ST_RND : ST_ITER;
                ST_ITER: if (w_cnt_zero) r_state <= ST_RND;
                ST_RND:  r_state <= ST_DONE;
                ST_DONE: if (div.div_res_ack) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are a pure decode of state and the captured precision; only the accept is combinational.
    always_comb begin
        div.div_req_ack           = w_accept;
        div.d1stg_step            = w_accept;
        div.div_busy              = (r_state != ST_IDLE);
        div.fdiv_clken_l          = !((r_state != ST_IDLE) || w_accept);
        div.div_res_vld           = (r_state == ST_DONE);
        div.d3stg_fdiv            = (r_state == ST_LZC);
        div.d4stg_fdiv            = (r_state == ST_PREP);
        div.d5stg_fdivb           = (r_state == ST_ITER);
        div.d6stg_fdiv            = (r_state == ST_RND);
        div.d6stg_fdivd           = (r_state == ST_RND) && r_dbl;
        div.d6stg_fdivs           = (r_state == ST_RND) && !r_dbl;
        div.div_frac_add_in1_add  = (r_state == ST_ITER);
        div.div_frac_add_in1_load = (r_state == ST_PREP) || (r_state == ST_ITER) || (r_state == ST_RND);
        div.div_frac_add_in2_load = (r_state == ST_PREP) || (r_state == ST_RND);
        div.div_frac_out_shl1_dbl = (r_state == ST_ITER) && r_dbl;
        div.div_frac_out_shl1_sng = (r_state == ST_ITER) && !r_dbl;
        div.div_frac_out_load     = (r_state == ST_PREP) || (r_state == ST_ITER);
    end

endmodule

// File: tb/tb_fpu_div_frac_seq.sv
// Bench for fpu_div_frac_seq: directed and random ops checked against a cycle-timeline model.
module tb_fpu_div_frac_seq;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 rclk = ~rclk;

    fpu_div_frac_seq_if u_if ();

    fpu_div_frac_seq u_dut (
        .rclk (rclk),
        .rst  (rst),
        .div  (u_if.slave)
    );

    // Expected outputs as a function of the cycle offset k from accept (k<0: idle).
    // Bit order: ack,step,busy,vld,clken_l,d3,d4,d5b,d6,d6d,d6s,add,in1l,in2l,shd,shs,outl
    function automatic logic [16:0] model(int k, int n, bit dbl, bit req);
        logic ack, step, busy, vld, clkl, d3, d4, d5b, d6, d6d, d6s;
        logic add, in1l, in2l, shd, shs, outl;
        {ack, step, busy, vld, d3, d4, d5b, d6, d6d, d6s, add, in1l, in2l, shd, shs, outl} = '0;
        clkl = 1'b1;
        if (k <= 0) begin
            ack  = (k == 0) || req;
            step = ack;
            clkl = !ack;
        end else begin
            busy = 1'b1;
            clkl = 1'b0;
            if (k == 2) d3 = 1'b1;
            if (k == 3) begin d4 = 1'b1; in1l = 1'b1; in2l = 1'b1; outl = 1'b1; end
            if (k >= 4 && k <= 3 + n) begin
                d5b = 1'b1; add = 1'b1; in1l = 1'b1; outl = 1'b1;
                shd = dbl; shs = !dbl;
            end
            if (k == 4 + n) begin d6 = 1'b1; d6d = dbl; d6s = !dbl; in1l = 1'b1; in2l = 1'b1; end
            if (k >= 5 + n) vld = 1'b1;
        end
        return {ack, step, busy, vld, clkl, d3, d4, d5b, d6, d6d, d6s, add, in1l, in2l, shd, shs, outl};
    endfunction

    function automatic logic [16:0] observed();
        return {u_if.div_req_ack, u_if.d1stg_step, u_if.div_busy, u_if.div_res_vld, u_if.fdiv_clken_l,
                u_if.d3stg_fdiv, u_if.d4stg_fdiv, u_if.d5stg_fdivb, u_if.d6stg_fdiv, u_if.d6stg_fdivd,
                u_if.d6stg_fdivs, u_if.div_frac_add_in1_add, u_if.div_frac_add_in1_load,
                u_if.div_frac_add_in2_load, u_if.div_frac_out_shl1_dbl, u_if.div_frac_out_shl1_sng,
                u_if.div_frac_out_load};
    endfunction

    task automatic check(input string tag, input int k, input logic [16:0] exp);
        logic [16:0] obs;
        @(negedge rclk);
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle_check(input string tag, input bit req);
        u_if.div_req = req;
        u_if.div_kill = 1'b0;
        u_if.div_res_ack = 1'b0;
        rst = 1'b0;
        check(tag, -1, model(-1, 0, 1'b0, req));
        if (!req) advance();
    endtask

    // One op from accept; ends after kill, reset or ack cycle. kill_at/rst_at < 0 disables them.
    task automatic run_op(input string tag, input bit dbl, input bit sp, input int kill_at,
                          input int rst_at, input int ack_dly, input bit hold, input bit kill_idle);
        int n;
        int ack_k;
        n = sp ? 0 : (dbl ? 55 : 26);
        ack_k = 5 + n + ack_dly;
        u_if.div_dbl = dbl;
        u_if.div_special = sp;
        for (int k = 0; k < 400; k++) begin
            u_if.div_req     = (k == 0) || hold;
            u_if.div_kill    = (k == kill_at) || (k == 0 && kill_idle);
            rst              = (k == rst_at);
            u_if.div_res_ack = (k == ack_k);
            if (k > 0) begin
                u_if.div_dbl     = $urandom_range(0, 1);
                u_if.div_special = $urandom_range(0, 1);
            end
            check(tag, k, model(k, n, dbl, 1'b1));
            advance();
            if (k == kill_at || k == rst_at || k == ack_k) break;
        end
        u_if.div_kill = 1'b0;
        u_if.div_res_ack = 1'b0;
        rst = 1'b0;
        if (!hold) u_if.div_req = 1'b0;
    endtask

    initial begin
        bit dbl, sp, hold, kidle;
        int kill_at, ack_dly;
        u_if.div_req = 1'b0;
        u_if.div_dbl = 1'b0;
        u_if.div_special = 1'b0;
        u_if.div_kill = 1'b0;
        u_if.div_res_ack = 1'b0;
        rst = 1'b1;
        advance();
        advance();
        check("reset", -1, model(-1, 0, 1'b0, 1'b0));
        idle_check("idle_after_reset", 1'b0);

        run_op("double", 1'b1, 1'b0, -1, -1, 3, 1'b0, 1'b0);
        idle_check("idle_after_dbl", 1'b0);
        run_op("single", 1'b0, 1'b0, -1, -1, 0, 1'b0, 1'b0);
        idle_check("idle_after_sng", 1'b0);
        run_op("special", 1'b1, 1'b1, -1, -1, 1, 1'b0, 1'b0);
        idle_check("idle_after_sp", 1'b0);
        run_op("kill20", 1'b1, 1'b0, 20, -1, 0, 1'b0, 1'b0);
        run_op("after_kill", 1'b0, 1'b0, -1, -1, 2, 1'b0, 1'b0);
        idle_check("idle_after_kill_op", 1'b0);
        run_op("held_req1", 1'b0, 1'b1, -1, -1, 2, 1'b1, 1'b0);
        run_op("held_req2", 1'b1, 1'b1, -1, -1, 0, 1'b0, 1'b0);
        idle_check("idle_after_held", 1'b0);
        run_op("kill_in_idle", 1'b0, 1'b1, -1, -1, 0, 1'b0, 1'b1);
        run_op("kill_with_ack", 1'b0, 1'b1, 5, -1, 0, 1'b0, 1'b0);
        idle_check("idle_after_kill_ack", 1'b0);
        run_op("rst_mid_iter", 1'b1, 1'b0, -1, 30, 0, 1'b0, 1'b0);
        idle_check("idle_after_rst", 1'b0);
        run_op("single_after_rst", 1'b0, 1'b0, -1, -1, 0, 1'b0, 1'b0);
        idle_check("idle_after_sng2", 1'b0);

        for (int i = 0; i < 25; i++) begin
            dbl     = $urandom_range(0, 1);
            sp      = ($urandom_range(0, 7) == 0);
            hold    = ($urandom_range(0, 3) == 0);
            kidle   = $urandom_range(0, 1);
            ack_dly = $urandom_range(0, 3);
            kill_at = ($urandom_range(0, 4) == 0) ?
                      int'($urandom_range(1, (sp ? 5 : (dbl ? 60 : 31)) + ack_dly)) : -1;
            run_op("random", dbl, sp, kill_at, -1, ack_dly, hold, kidle);
            if (!hold && $urandom_range(0, 1) == 1) idle_check("random_idle", 1'b0);
        end
        idle_check("final_idle", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
